// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests to instruction
// memory, and hands instr/pc pairs to decode over a valid/ready handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq,
  output logic [31:0] iaddr,
  input  logic        ivalid,
  input  logic [31:0] idata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        misalign_err_q, misalign_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      fetch_pc_q     <= RESET_PC;
      pending_pc_q   <= RESET_PC;
      instr_q        <= NOP_INSTR;
      pc_q           <= RESET_PC;
      instr_valid_q  <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      pending_pc_q   <= pending_pc_d;
      instr_q        <= instr_d;
      pc_q           <= pc_d;
      instr_valid_q  <= instr_valid_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    pending_pc_d   = pending_pc_q;
    instr_d        = instr_q;
    pc_d           = pc_q;
    instr_valid_d  = instr_valid_q;
    misalign_err_d = misalign_err_q;

    // A misaligned target wins over everything except reset; ERR itself is terminal.
    if (state_q != S_ERR && redirect && redirect_pc[1:0] != 2'b00) begin
      state_d        = S_ERR;
      misalign_err_d = 1'b1;
      pc_d           = redirect_pc;
      instr_d        = NOP_INSTR;
      instr_valid_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (redirect) fetch_pc_d = redirect_pc;
          state_d = S_REQ;
        end
        S_REQ: begin
          if (redirect) begin
            if (ivalid) begin
              fetch_pc_d = redirect_pc;
            end else begin
              pending_pc_d = redirect_pc;
              state_d      = S_DRAIN;
            end
          end else if (ivalid) begin
            instr_d       = idata;
            pc_d          = fetch_pc_q;
            instr_valid_d = 1'b1;
            fetch_pc_d    = fetch_pc_q + 32'd4;
            state_d       = S_HOLD;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            instr_valid_d = 1'b0;
            instr_d       = NOP_INSTR;
            fetch_pc_d    = redirect_pc;
            state_d       = S_REQ;
          end else if (instr_ready) begin
            instr_valid_d = 1'b0;
            instr_d       = NOP_INSTR;
            state_d       = S_REQ;
          end
        end
        S_DRAIN: begin
          // A redirect coinciding with the drained response is the newest target.
          if (redirect && ivalid) begin
            fetch_pc_d = redirect_pc;
            state_d    = S_REQ;
          end else if (redirect) begin
            pending_pc_d = redirect_pc;
          end else if (ivalid) begin
            fetch_pc_d = pending_pc_q;
            state_d    = S_REQ;
          end
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ireq         = (state_q == S_REQ) || (state_q == S_DRAIN);
    iaddr        = fetch_pc_q;
    instr        = instr_q;
    pc           = pc_q;
    instr_valid  = instr_valid_q;
    misalign_err = misalign_err_q;
  end

endmodule
